// File: rtl/tetris_pkg.sv
// Shared playfield definitions: default piece-mask size, extent-scanner states
// and the row-major mask bit-index convention used by rotation/collision blocks.
package tetris_pkg;

    localparam int BLOCK_N = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } scan_state_t;

    // Bit index of row r (0 = top), column c (0 = left) in an n x n mask.
    function automatic int mask_bit(input int r, input int c, input int n);
        return r * n + c;
    endfunction

endpackage

// File: rtl/first_last_set.sv
// Combinational first/last set-bit finder over an N-bit vector.
// Reused for column extents and by the row-clear logic.
module first_last_set
    import tetris_pkg::*;
#(
    parameter  int N = BLOCK_N,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] first,
    output logic [W-1:0] last,
    output logic         none
);

    always_comb begin
        first = '0;
        last  = '0;
        // Descending pass leaves the lowest set index; ascending leaves the highest.
        for (int c = N - 1; c >= 0; c--) begin
            if (vec[c]) first = W'(c);
        end
        for (int c = 0; c < N; c++) begin
            if (vec[c]) last = W'(c);
        end
    end

    assign none = ~|vec;

endmodule

// File: rtl/block_extent_scan.sv
// Sequential N x N mask extent scanner: one row per clock, reporting
// top/bottom rows, left/right columns and an empty flag behind valid/ready.
module block_extent_scan
    import tetris_pkg::*;
#(
    parameter  int N = BLOCK_N,
    localparam int W = $clog2(N)
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*N-1:0] mask,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   top,
    output logic [W-1:0]   bottom,
    output logic [W-1:0]   left,
    output logic [W-1:0]   right,
    output logic           empty
);

    scan_state_t    state_q, state_d;
    logic [N*N-1:0] mask_q, mask_d;
    logic [W-1:0]   row_q, row_d;
    logic [N-1:0]   acc_q, acc_d;
    logic           found_q, found_d;
    logic [W-1:0]   top_q, top_d;
    logic [W-1:0]   bottom_q, bottom_d;
    logic [W-1:0]   left_q, left_d;
    logic [W-1:0]   right_q, right_d;
    logic           empty_q, empty_d;

    logic [N-1:0]   rows [N];
    logic [N-1:0]   cur_row;
    logic [N-1:0]   acc_next;
    logic [W-1:0]   fls_first;
    logic [W-1:0]   fls_last;
    logic           fls_none;

    for (genvar gi = 0; gi < N; gi++) begin : g_rows
        assign rows[gi] = mask_q[mask_bit(gi, 0, N) +: N];
    end

    assign cur_row  = rows[row_q];
    // Includes the row being processed so the last edge sees row N-1's bits.
    assign acc_next = acc_q | cur_row;

    first_last_set #(.N(N)) u_col_extent (
        .vec   (acc_next),
        .first (fls_first),
        .last  (fls_last),
        .none  (fls_none)
    );

    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        row_d    = row_q;
        acc_d    = acc_q;
        found_d  = found_q;
        top_d    = top_q;
        bottom_d = bottom_q;
        left_d   = left_q;
        right_d  = right_q;
        empty_d  = empty_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d  = SCAN;
                    mask_d   = mask;
                    row_d    = '0;
                    acc_d    = '0;
                    found_d  = 1'b0;
                    top_d    = '0;
                    bottom_d = '0;
                end
            end
            SCAN: begin
                acc_d = acc_next;
                if (|cur_row) begin
                    if (!found_q) begin
                        top_d   = row_q;
                        found_d = 1'b1;
                    end
                    bottom_d = row_q;
                end
                if (row_q == W'(N - 1)) begin
                    state_d = DONE;
                    left_d  = fls_first;
                    right_d = fls_last;
                    empty_d = fls_none;
                end else begin
                    row_d = row_q + W'(1);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            mask_q   <= '0;
            row_q    <= '0;
            acc_q    <= '0;
            found_q  <= 1'b0;
            top_q    <= '0;
            bottom_q <= '0;
            left_q   <= '0;
            right_q  <= '0;
            empty_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            row_q    <= row_d;
            acc_q    <= acc_d;
            found_q  <= found_d;
            top_q    <= top_d;
            bottom_q <= bottom_d;
            left_q   <= left_d;
            right_q  <= right_d;
            empty_q  <= empty_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign top       = top_q;
    assign bottom    = bottom_q;
    assign left      = left_q;
    assign right     = right_q;
    assign empty     = empty_q;

endmodule

// File: doc/block_extent_scan.md
# block_extent_scan

Parametrised, sequential extent scanner for an N×N tetromino mask. It replaces the combinational bottom-row finder in the playfield datapath and reports top row, bottom row, left column, right column and an empty flag. It scans one mask row per clock behind valid/ready handshakes on both sides. It sits between the piece-rotation logic and the collision/landing checker, which uses the extents to bound its field comparisons.

## Interface
- `N`, 4: mask side length; legal range 2..8.
- `W`, `$clog2(N)`: extent output width; derived, not overridden.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `mask` is valid.
- `in_ready`  out  1  block can accept a mask.
- `mask`  in  N*N  piece mask. Bit `r*N+c` is row r (0 = top), column c (0 = left).
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `top`  out  W  lowest-index row containing a set bit.
- `bottom`  out  W  highest-index row containing a set bit.
- `left`  out  W  lowest-index column containing a set bit.
- `right`  out  W  highest-index column containing a set bit.
- `empty`  out  1  mask had no set bits.

## Operation
- FSM states:
  - IDLE: `in_ready`=1, `out_valid`=0.
  - SCAN: `in_ready`=0, `out_valid`=0.
  - DONE: `in_ready`=0, `out_valid`=1.
- IDLE → SCAN when `in_valid && in_ready`. On that edge:
  - `mask` is captured into an internal register.
  - Row counter is set to 0.
  - Column accumulator is cleared.
  - The `found` flag is cleared.
- SCAN, each cycle, process row `row_cnt`:
  - Row bits are OR'd into the N-bit column accumulator.
  - If the row is nonzero and `found`=0: `top`←row, `found`←1.
  - If the row is nonzero: `bottom`←row.
- SCAN → DONE on the edge that processes row N-1. On that edge:
  - `left`/`right` load from the first/last set bit of the final accumulator, including row N-1's bits.
  - `empty` ← no set bit anywhere in the mask.
- DONE → IDLE when `out_ready`=1. Outputs hold their values until the next capture.
- Empty mask: `top`=`bottom`=`left`=`right`=0, `empty`=1. `out_valid` still asserts on schedule.
- `in_valid` outside IDLE is ignored; the upstream must hold it.
- `mask` changes after capture have no effect.
- Arithmetic: row counter is W bits and never wraps; the transition on row N-1 stops it.
- Extents are unsigned row/column indices. The invariants `top`≤`bottom` and `left`≤`right` hold whenever `empty`=0.

## Timing
- Reset (asynchronous assert, synchronous release):
  - State → IDLE.
  - `in_ready`=1, `out_valid`=0.
  - `top`=`bottom`=`left`=`right`=0, `empty`=1.
- Latency: capture at edge E → `out_valid` high in the cycle after edge E+N.
- Minimum occupancy is N+2 cycles per mask: capture, N scan edges, handshake edge.
- Back-pressure: `out_valid` and all result outputs are stable while `out_ready`=0.
- Reset during SCAN or DONE aborts the operation:
  - No result is emitted.
  - The first cycle after release shows `in_ready`=1.
- `in_ready` depends only on state (a registered decode), not combinationally on `out_ready`.

## Structure
- Shared package `tetris_pkg` holds:
  - `BLOCK_N` (4), default for `N`.
  - `scan_state_t` enum {IDLE, SCAN, DONE}.
  - Mask bit-index convention `r*N+c`, also used by the rotation and collision blocks.
- Sub-module `first_last_set #(N)`, combinational:
  - N-bit input; outputs `first`, `last` (W bits) and `none`.
  - Used for `left`/`right` from the accumulator.
  - Reusable by the row-clear logic.
- Top-level holds the FSM, the row counter, the mask/accumulator registers and the top/bottom tracking.

## Test plan
- N=4, `mask`=0x00F0 (horizontal I in row 1), `out_ready`=1:
  - `out_valid` rises in the cycle after edge E+4.
  - `top`=1, `bottom`=1, `left`=0, `right`=3, `empty`=0.
- N=4, `mask`=0x0660 (O piece) → `top`=1, `bottom`=2, `left`=1, `right`=2.
- N=4, `mask`=0x8888 (vertical I in column 3) → `top`=0, `bottom`=3, `left`=3, `right`=3.
- N=4, `mask`=0x8000 → all extents 3.
- N=4, `mask`=0x0000 → `empty`=1, all extents 0, `out_valid` still on schedule.
- Back-pressure and reset:
  - Hold `out_ready`=0 for 5 cycles after `out_valid`; present a second mask meanwhile.
  - Required: outputs stable, `in_ready`=0, second mask not captured until after the `out_ready` handshake.
  - Assert `resetn`=0 mid-SCAN: `out_valid` never asserts for that mask, and outputs return to reset values immediately.
- N=8, `mask` with only bit 63 set → all extents 7.
- N=8, `mask` with bits 8 and 55 set → `top`=1, `bottom`=6, `left`=0, `right`=7.
- N=8 latency: `out_valid` rises in the cycle after edge E+8.
